// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock period meter.
package clk_meas_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Rising edges needed after reset or a stall before a result appears.
    localparam int ACQUIRE_RISES = 2;

    // Increment value, holding at the all-ones pattern of the given width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Synchronizer chain for an asynchronous input plus rising-edge detector.
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_prev_reg;

    // Shift sig_in through the synchronizer and keep one cycle of history.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_reg   <= '0;
            s_prev_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            s_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_prev_reg;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of sig_in in clock_in cycles.
module clock_period_meter
    import clk_meas_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT     = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_count,
    output logic [WIDTH-1:0] high_count,
    output logic             result_valid,
    output logic [15:0]      result_seq,
    output logic             stalled
);

    // Compared at 64 bits so a TIMEOUT beyond the counter range never fires.
    localparam logic [63:0] TIMEOUT_L = 64'(TIMEOUT);

    logic s;
    logic rise;

    edge_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync_detect (
        .clock_in(clock_in),
        .reset   (reset),
        .sig_in  (sig_in),
        .s       (s),
        .rise    (rise)
    );

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] hcnt_reg, hcnt_next;
    logic [WIDTH-1:0] period_reg, period_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic             valid_reg, valid_next;
    logic [15:0]      seq_reg, seq_next;
    logic             stalled_reg, stalled_next;
    logic             timeout_hit;

    assign timeout_hit = (64'(cnt_reg) == TIMEOUT_L);

    // State, counter and result registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg   <= ACQUIRE;
            cnt_reg     <= '0;
            hcnt_reg    <= '0;
            period_reg  <= '0;
            high_reg    <= '0;
            valid_reg   <= 1'b0;
            seq_reg     <= '0;
            stalled_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hcnt_reg    <= hcnt_next;
            period_reg  <= period_next;
            high_reg    <= high_next;
            valid_reg   <= valid_next;
            seq_reg     <= seq_next;
            stalled_reg <= stalled_next;
        end
    end

    // Next-state logic: acquire a reference edge, then count and report per rise.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hcnt_next    = hcnt_reg;
        period_next  = period_reg;
        high_next    = high_reg;
        valid_next   = 1'b0;
        seq_next     = seq_reg;
        stalled_next = stalled_reg;

        if (rise) begin
            stalled_next = 1'b0;
        end

        case (state_reg)
            ACQUIRE: begin
                if (rise) begin
                    cnt_next   = WIDTH'(1);
                    hcnt_next  = WIDTH'(1);
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    // A rise coinciding with the timeout still closes a valid period.
                    period_next = cnt_reg;
                    high_next   = hcnt_reg;
                    valid_next  = 1'b1;
                    seq_next    = seq_reg + 16'd1;
                    cnt_next    = WIDTH'(1);
                    hcnt_next   = WIDTH'(1);
                end else if (timeout_hit) begin
                    stalled_next = 1'b1;
                    state_next   = ACQUIRE;
                end else begin
                    cnt_next = WIDTH'(sat_inc(64'(cnt_reg), WIDTH));
                    if (s) begin
                        hcnt_next = WIDTH'(sat_inc(64'(hcnt_reg), WIDTH));
                    end
                end
            end
            default: begin
                state_next = ACQUIRE;
            end
        endcase
    end

    assign period_count = period_reg;
    assign high_count   = high_reg;
    assign result_valid = valid_reg;
    assign result_seq   = seq_reg;
    assign stalled      = stalled_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: vector table plus corner sequences.
module tb_clock_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;

    logic [31:0] period_count, high_count;
    logic        result_valid, stalled;
    logic [15:0] result_seq;

    logic [3:0]  p2, h2;
    logic        v2, st2;
    logic [15:0] seq2;

    always #5 clk = ~clk;

    clock_period_meter #(.WIDTH(32), .TIMEOUT(20), .SYNC_STAGES(2)) dut (
        .clock_in    (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .period_count(period_count),
        .high_count  (high_count),
        .result_valid(result_valid),
        .result_seq  (result_seq),
        .stalled     (stalled)
    );

    // Narrow instance whose counters saturate before its timeout can fire.
    clock_period_meter #(.WIDTH(4), .TIMEOUT(50), .SYNC_STAGES(2)) dut_sat (
        .clock_in    (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .period_count(p2),
        .high_count  (h2),
        .result_valid(v2),
        .result_seq  (seq2),
        .stalled     (st2)
    );

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic [15:0] q;
    } res_t;

    typedef struct {
        int high;
        int low;
        int periods;
        int exp_results;
        int exp_period;
        int exp_high;
        int exp_seq;
    } vec_t;

    res_t res_q[$];
    res_t res2_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect result pulses from both instances; result_valid must never repeat.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (result_valid) begin
                res_q.push_back('{period_count, high_count, result_seq});
                last_valid_cyc = cyc;
                total++;
                if (prev_valid) begin
                    bad++;
                    $display("FAIL valid_back_to_back: got 1 on consecutive cycles, required isolated pulse");
                end
            end
            prev_valid = result_valid;
            if (v2) res2_q.push_back('{32'(p2), 32'(h2), seq2});
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) tick();
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period_count, 0);
        check({tag, "_high"}, high_count, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_seq"}, result_seq, 0);
        check({tag, "_stalled"}, stalled, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   nz;
        int   t0;
        int   waited;

        // high, low, periods, results seen, last period, last high, last seq
        vecs[0] = '{3, 3, 4, 3,  6,  3,  3};
        vecs[1] = '{2, 4, 3, 3,  6,  2,  6};
        vecs[2] = '{5, 1, 4, 4,  6,  5, 10};
        vecs[3] = '{1, 1, 5, 4,  2,  1, 14};
        vecs[4] = '{2, 2, 3, 4,  4,  2, 18};
        vecs[5] = '{17, 3, 2, 2, 20, 17, 20};
        vecs[6] = '{3, 3, 3, 3,  6,  3, 23};

        reset  = 1'b1;
        sig_in = 1'b0;
        tick();
        tick();

        // Square wave running while reset is held: outputs stay at zero.
        nz = 0;
        for (int i = 0; i < 12; i++) begin
            sig_in = (i % 4) >= 2;
            tick();
            if (period_count != 0 || high_count != 0 || result_valid || result_seq != 0 || stalled)
                nz++;
        end
        check("reset_nonzero_cycles", nz, 0);
        check_zero("reset");

        reset  = 1'b0;
        sig_in = 1'b0;
        drive(1'b0, 5);
        res_q.delete();
        res2_q.delete();

        for (int i = 0; i < 7; i++) begin
            if (i == 5) res2_q.delete();
            wave(vecs[i].high, vecs[i].low, vecs[i].periods);
            check($sformatf("vec%0d_results", i), res_q.size(), vecs[i].exp_results);
            if (res_q.size() > 0) begin
                check($sformatf("vec%0d_period", i), res_q[$].p, vecs[i].exp_period);
                check($sformatf("vec%0d_high", i), res_q[$].h, vecs[i].exp_high);
                check($sformatf("vec%0d_seq", i), res_q[$].q, vecs[i].exp_seq);
            end
            check($sformatf("vec%0d_seq_out", i), result_seq, vecs[i].exp_seq);
            check($sformatf("vec%0d_stalled", i), stalled, 0);
            if (i == 5) begin
                check("sat_results", res2_q.size(), 2);
                if (res2_q.size() > 0) begin
                    check("sat_period", res2_q[$].p, 15);
                    check("sat_high", res2_q[$].h, 15);
                end
                check("sat_period_out", p2, 15);
                check("sat_stalled", st2, 0);
            end
            res_q.delete();
        end

        // Hold low after a period-6 result: stall 20 cycles after the last rise.
        t0 = last_valid_cyc;
        waited = 0;
        while (!stalled && waited < 40) begin
            tick();
            waited++;
        end
        check("stall_delay", cyc - t0, 20);
        check("stall_level", stalled, 1);
        check("stall_hold_period", period_count, 6);
        check("stall_hold_high", high_count, 3);
        drive(1'b0, 4);
        check("stall_no_result", res_q.size(), 0);

        // First rise clears stalled without a result; the second reports.
        wave(3, 3, 1);
        check("reacq_first_results", res_q.size(), 0);
        check("reacq_stall_cleared", stalled, 0);
        wave(3, 3, 1);
        check("reacq_results", res_q.size(), clk_meas_pkg::ACQUIRE_RISES - 1);
        if (res_q.size() > 0) begin
            check("reacq_period", res_q[0].p, 6);
            check("reacq_high", res_q[0].h, 3);
            check("reacq_seq", res_q[0].q, 24);
        end
        res_q.delete();

        // Reset three cycles into a period, then period-4 input.
        wave(2, 2, 3);
        drive(1'b1, 2);
        drive(1'b0, 1);
        reset = 1'b1;
        drive(1'b0, 1);
        drive(1'b1, 2);
        check_zero("midreset");
        reset = 1'b0;
        drive(1'b0, 2);
        res_q.delete();
        wave(2, 2, 3);
        check("post_reset_results", res_q.size(), 2);
        if (res_q.size() > 1) begin
            check("post_reset_first_seq", res_q[0].q, 1);
            check("post_reset_period", res_q[$].p, 4);
            check("post_reset_high", res_q[$].h, 2);
            check("post_reset_seq", res_q[$].q, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
